// File: rtl/rcu_pll_seq.sv
// PLL bring-up and core clock switch sequencer for the reset/clock unit.
// Runs on the always-on bypass clock: configure, lock, switch, release resets, then watch for lock loss.
module rcu_pll_seq #(
  parameter int          TMO_WIDTH     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int          LOCK_STABLE   = 4,
  parameter int          SETTLE_CYC    = 8,
  parameter int          RST_STAGE_CYC = 4,
  parameter int          NUM_DOM       = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               bypass_i,
  input  logic [2:0]         clk_cfg_i,
  input  logic               pll_lock_i,
  output logic               pll_en_o,
  output logic [2:0]         clk_cfg_o,
  output logic               sel_pll_o,
  output logic [NUM_DOM-1:0] rst_release_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               lock_lost_o,
  output logic [2:0]         state_o
);

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam logic [TMO_WIDTH-1:0] TMO_TGT     = TMO_WIDTH'(LOCK_TIMEOUT);
  localparam logic [TMO_WIDTH-1:0] SETTLE_LAST = TMO_WIDTH'(SETTLE_CYC - 1);
  localparam logic [TMO_WIDTH-1:0] STAGE_LAST  = TMO_WIDTH'(RST_STAGE_CYC - 1);
  localparam logic [SW-1:0]        STAB_TGT    = SW'(LOCK_STABLE);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG       = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SWITCH    = 3'd3,
    ST_RST_REL   = 3'd4,
    ST_RUN       = 3'd5,
    ST_ERR       = 3'd6
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [TMO_WIDTH-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [SW-1:0]        stab_r, stab_nxt_s;
  logic [1:0]           sync_r;
  logic                 lock_s;
  logic                 pll_en_r, pll_en_nxt_s;
  logic [2:0]           cfg_r, cfg_nxt_s;
  logic                 sel_r, sel_nxt_s;
  logic [NUM_DOM-1:0]   rel_r, rel_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 done_r, done_nxt_s;
  logic                 err_r, err_nxt_s;
  logic                 lost_r, lost_nxt_s;

  assign lock_s    = sync_r[1];
  assign cnt_inc_s = (cnt_r == {TMO_WIDTH{1'b1}}) ? cnt_r : cnt_r + TMO_WIDTH'(1);

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    stab_nxt_s   = stab_r;
    pll_en_nxt_s = pll_en_r;
    cfg_nxt_s    = cfg_r;
    sel_nxt_s    = sel_r;
    rel_nxt_s    = rel_r;
    done_nxt_s   = 1'b0;
    err_nxt_s    = err_r;
    lost_nxt_s   = lost_r;
    case (state_r)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if ((state_r == ST_RUN) && sel_r && !lock_s) begin
          state_nxt_s  = ST_ERR;
          lost_nxt_s   = 1'b1;
          sel_nxt_s    = 1'b0;
          rel_nxt_s    = '0;
          pll_en_nxt_s = 1'b0;
        end else if (start_i) begin
          // Mux and PLL are dropped together so the mux never sees a PLL under reconfiguration.
          err_nxt_s    = 1'b0;
          sel_nxt_s    = 1'b0;
          pll_en_nxt_s = 1'b0;
          cnt_nxt_s    = '0;
          if (bypass_i) begin
            state_nxt_s = ST_RST_REL;
            rel_nxt_s   = NUM_DOM'(1);
          end else begin
            state_nxt_s = ST_CFG;
            cfg_nxt_s   = clk_cfg_i;
            rel_nxt_s   = '0;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CFG: begin
        if (cnt_r == SETTLE_LAST) begin
          state_nxt_s  = ST_WAIT_LOCK;
          cnt_nxt_s    = '0;
          stab_nxt_s   = '0;
          pll_en_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      ST_WAIT_LOCK: begin
        cnt_nxt_s  = cnt_inc_s;
        stab_nxt_s = lock_s ? stab_r + SW'(1) : '0;
        if (stab_nxt_s == STAB_TGT) begin
          state_nxt_s = ST_SWITCH;
          sel_nxt_s   = 1'b1;
          cnt_nxt_s   = '0;
        end else if (cnt_inc_s == TMO_TGT) begin
          state_nxt_s  = ST_ERR;
          err_nxt_s    = 1'b1;
          pll_en_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      end
      ST_SWITCH: begin
        if (cnt_r == SETTLE_LAST) begin
          state_nxt_s = ST_RST_REL;
          cnt_nxt_s   = '0;
          rel_nxt_s   = NUM_DOM'(1);
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      ST_RST_REL: begin
        // Releases stay contiguous from bit 0, so OR-ing in a left shift sets exactly the next domain.
        if (rel_r[NUM_DOM-1]) begin
          state_nxt_s = ST_RUN;
          done_nxt_s  = 1'b1;
        end else if (cnt_r == STAGE_LAST) begin
          cnt_nxt_s = '0;
          rel_nxt_s = rel_r | (rel_r << 1);
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    case (state_nxt_s)
      ST_CFG, ST_WAIT_LOCK, ST_SWITCH, ST_RST_REL: busy_nxt_s = 1'b1;
      default:                                      busy_nxt_s = 1'b0;
    endcase
  end

  // State, counters, lock synchronizer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      stab_r   <= '0;
      sync_r   <= 2'b00;
      pll_en_r <= 1'b0;
      cfg_r    <= 3'd0;
      sel_r    <= 1'b0;
      rel_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      lost_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      stab_r   <= stab_nxt_s;
      sync_r   <= {sync_r[0], pll_lock_i};
      pll_en_r <= pll_en_nxt_s;
      cfg_r    <= cfg_nxt_s;
      sel_r    <= sel_nxt_s;
      rel_r    <= rel_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
      err_r    <= err_nxt_s;
      lost_r   <= lost_nxt_s;
    end
  end

  assign pll_en_o      = pll_en_r;
  assign clk_cfg_o     = cfg_r;
  assign sel_pll_o     = sel_r;
  assign rst_release_o = rel_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign err_o         = err_r;
  assign lock_lost_o   = lost_r;
  assign state_o       = state_r;

endmodule

// File: tb/tb_rcu_pll_seq.sv
// Self-checking bench for rcu_pll_seq: directed bring-up scenarios plus a random soak,
// every cycle compared against a phase/elapsed-time reference model.
module tb_rcu_pll_seq;

  localparam int TMO   = 100;
  localparam int STAB  = 4;
  localparam int SETTLE = 8;
  localparam int STAGE = 4;
  localparam int NDOM  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       bypass = 1'b0;
  logic [2:0] cfg_in = 3'd0;
  logic       lock = 1'b0;
  logic       pll_en, sel_pll, busy, done, err, lock_lost;
  logic [2:0] clk_cfg, state;
  logic [NDOM-1:0] rst_rel;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // Reference model: phase, cycles elapsed in phase, consecutive lock count, domains released.
  int m_ph, m_el, m_stab, m_nrel, m_cfg;
  int m_en, m_sel, m_busy, m_done, m_err, m_lost;
  int h0, h1;

  rcu_pll_seq #(
    .TMO_WIDTH(16), .LOCK_TIMEOUT(TMO), .LOCK_STABLE(STAB),
    .SETTLE_CYC(SETTLE), .RST_STAGE_CYC(STAGE), .NUM_DOM(NDOM)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bypass_i(bypass),
    .clk_cfg_i(cfg_in), .pll_lock_i(lock), .pll_en_o(pll_en),
    .clk_cfg_o(clk_cfg), .sel_pll_o(sel_pll), .rst_release_o(rst_rel),
    .busy_o(busy), .done_o(done), .err_o(err), .lock_lost_o(lock_lost),
    .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_launch();
    m_err = 0; m_sel = 0; m_en = 0; m_el = 0;
    if (bypass) begin m_ph = 4; m_nrel = 1; end
    else begin m_ph = 1; m_cfg = int'(cfg_in); m_nrel = 0; end
  endtask

  task automatic model_step();
    int ls;
    ls = h1; h1 = h0; h0 = int'(lock);
    m_done = 0;
    if (rst) begin
      m_ph = 0; m_el = 0; m_stab = 0; m_nrel = 0; m_cfg = 0;
      m_en = 0; m_sel = 0; m_err = 0; m_lost = 0; h0 = 0; h1 = 0;
    end else begin
      case (m_ph)
        0: if (start) model_launch();
        6: if (start) model_launch();
        5: begin
          if (m_sel == 1 && ls == 0) begin
            m_ph = 6; m_lost = 1; m_sel = 0; m_nrel = 0; m_en = 0;
          end else if (start) model_launch();
        end
        1: begin
          m_el++;
          if (m_el == SETTLE) begin m_ph = 2; m_el = 0; m_stab = 0; m_en = 1; end
        end
        2: begin
          m_el++;
          m_stab = ls ? m_stab + 1 : 0;
          if (m_stab == STAB) begin m_ph = 3; m_sel = 1; m_el = 0; end
          else if (m_el == TMO) begin m_ph = 6; m_err = 1; m_en = 0; end
        end
        3: begin
          m_el++;
          if (m_el == SETTLE) begin m_ph = 4; m_nrel = 1; m_el = 0; end
        end
        4: begin
          if (m_nrel == NDOM) begin m_ph = 5; m_done = 1; end
          else begin
            m_el++;
            if (m_el == STAGE) begin m_nrel++; m_el = 0; end
          end
        end
        default: m_ph = 0;
      endcase
    end
    m_busy = (m_ph >= 1 && m_ph <= 4) ? 1 : 0;
  endtask

  task automatic check_all();
    check_eq("state",   state,     m_ph);
    check_eq("pll_en",  pll_en,    m_en);
    check_eq("clk_cfg", clk_cfg,   m_cfg);
    check_eq("sel_pll", sel_pll,   m_sel);
    check_eq("rst_rel", rst_rel,   (32'd1 << m_nrel) - 32'd1);
    check_eq("busy",    busy,      m_busy);
    check_eq("done",    done,      m_done);
    check_eq("err",     err,       m_err);
    check_eq("lost",    lock_lost, m_lost);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_start(input logic byp, input logic [2:0] c);
    start = 1'b1; bypass = byp; cfg_in = c;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_state(input int ph, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== 3'(ph) && n < budget) begin cycle(); n++; end
    check_eq(tag, state, ph);
  endtask

  initial begin
    int n;
    logic [2:0] c;
    m_ph = 0; m_el = 0; m_stab = 0; m_nrel = 0; m_cfg = 0;
    m_en = 0; m_sel = 0; m_busy = 0; m_done = 0; m_err = 0; m_lost = 0;
    h0 = 0; h1 = 0;
    @(negedge clk);
    cycle(); cycle();
    check_eq("reset_state", state, 0);
    rst = 1'b0;

    // Full PLL bring-up with lock arriving 20 cycles after start.
    done_cnt = 0;
    pulse_start(1'b0, 3'd5);
    for (int i = 0; i < 20; i++) cycle();
    lock = 1'b1;
    wait_state(5, 200, "s1_reach_run");
    cycle(); cycle();
    check_eq("s1_rel_full", rst_rel, 6'h3F);
    check_eq("s1_cfg", clk_cfg, 3'd5);
    check_eq("s1_done_once", done_cnt, 1);
    check_eq("s1_busy_low", busy, 1'b0);

    // Lock loss while running on the PLL.
    lock = 1'b0;
    wait_state(6, 10, "s4_reach_err");
    check_eq("s4_lost", lock_lost, 1'b1);
    check_eq("s4_sel", sel_pll, 1'b0);
    check_eq("s4_rel", rst_rel, 6'h00);

    // Lock timeout from WAIT_LOCK entry.
    c = 3'($urandom);
    pulse_start(1'b0, c);
    wait_state(2, 20, "s2_reach_wait");
    n = 0;
    do begin cycle(); n++; end while (state !== 3'd6 && n < 200);
    check_eq("s2_tmo_cycles", n, TMO);
    check_eq("s2_err", err, 1'b1);
    check_eq("s2_pll_en", pll_en, 1'b0);
    check_eq("s2_rel", rst_rel, 6'h00);
    check_eq("s2_lost_sticky", lock_lost, 1'b1);
    pulse_start(1'b0, 3'($urandom));
    check_eq("s2_err_clr", err, 1'b0);

    // Short lock glitch must not count as a stable lock.
    wait_state(2, 20, "s3_reach_wait");
    lock = 1'b1; for (int i = 0; i < 3; i++) cycle();
    lock = 1'b0; for (int i = 0; i < 3; i++) cycle();
    check_eq("s3_no_switch", state, 2);
    lock = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (state !== 3'd3 && n < 50);
    check_eq("s3_stable_cycles", n, STAB + 2);
    wait_state(5, 200, "s3_reach_run");

    // Bypass restart from RUN.
    pulse_start(1'b1, 3'($urandom));
    n = 0;
    while (rst_rel !== 6'h3F && n < 100) begin cycle(); n++; end
    check_eq("s5_rel_cycles", n, (NDOM - 1) * STAGE);
    check_eq("s5_pll_en", pll_en, 1'b0);
    check_eq("s5_sel", sel_pll, 1'b0);
    wait_state(5, 10, "s5_reach_run");

    // Reset in the middle of reset release, with ignored starts while busy.
    pulse_start(1'b1, 3'($urandom));
    n = 0;
    while (rst_rel !== 6'h07 && n < 100) begin
      start = ($urandom_range(0, 1) == 0); bypass = 1'b0;
      cycle(); n++;
    end
    start = 1'b0;
    check_eq("s6_rel7", rst_rel, 6'h07);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("s6_state", state, 0);
    check_eq("s6_rel", rst_rel, 6'h00);

    // Random soak.
    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(0, 39) == 0);
      bypass = ($urandom_range(0, 2) == 0);
      cfg_in = 3'($urandom);
      if ($urandom_range(0, 29) == 0) lock = ~lock;
      rst    = ($urandom_range(0, 599) == 0);
      cycle();
    end
    rst = 1'b0; start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
